pipe_add: RTL and testbench

PIPE_ADD -- requirements
Module: pipe_add

---
 rtl/pipe_add_if.sv | 29 ++
 rtl/pipe_add.sv | 114 +++++++++++
 tb/tb_pipe_add.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_add_if.sv
// Handshake and operand/result bundle for the chunked pipelined adder.
// The producer side uses master; the adder itself uses slave.
interface pipe_add_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zr, ng
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zr, ng
    );
endinterface

// File: rtl/pipe_add.sv
// Carry-chunked pipelined adder/subtractor: one CHUNK-bit slice per stage,
// latency WIDTH/CHUNK, with a single global stall driven by the output handshake.
module pipe_add #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic       clk,
    input logic       reset_n,
    pipe_add_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH < 1 || WIDTH > 64 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipe_add: WIDTH must be 1..64 and a multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] eff_b;
    logic             eff_c;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign eff_b        = bus.sub ? ~bus.b : bus.b;
    assign eff_c        = bus.sub ? 1'b1 : bus.cin;

    // Each stage holds only what is still needed: the unprocessed upper operand
    // bits and the completed lower sum bits, so register widths shrink/grow per stage.
    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO      = gi * CHUNK;
        localparam int REM_IN  = WIDTH - LO;
        localparam int REM_OUT = REM_IN - CHUNK;

        logic [REM_IN-1:0]     a_in;
        logic [REM_IN-1:0]     b_in;
        logic                  c_in;
        logic                  v_in;
        logic [CHUNK:0]        part;
        logic [LO+CHUNK-1:0]   sum_d;
        logic [LO+CHUNK-1:0]   sum_q;
        logic                  valid_q;
        logic                  carry_q;

        if (gi == 0) begin : g_src
            assign a_in  = bus.a;
            assign b_in  = eff_b;
            assign c_in  = eff_c;
            assign v_in  = bus.in_valid;
            assign sum_d = part[CHUNK-1:0];
        end else begin : g_src
            assign a_in  = g_stage[gi-1].g_fwd.a_q;
            assign b_in  = g_stage[gi-1].g_fwd.b_q;
            assign c_in  = g_stage[gi-1].carry_q;
            assign v_in  = g_stage[gi-1].valid_q;
            assign sum_d = {part[CHUNK-1:0], g_stage[gi-1].sum_q};
        end

        assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= v_in;
                carry_q <= part[CHUNK];
                sum_q   <= sum_d;
            end
        end

        if (REM_OUT > 0) begin : g_fwd
            logic [REM_OUT-1:0] a_q;
            logic [REM_OUT-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[REM_IN-1:CHUNK];
                    b_q <= b_in[REM_IN-1:CHUNK];
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            logic ovf_q;
            logic zr_q;
            logic ng_q;

            // The top slice still carries the operand MSBs, so the flags are
            // resolved here on the same edge the final sum chunk is captured.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                    zr_q  <= 1'b0;
                    ng_q  <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (a_in[REM_IN-1] == b_in[REM_IN-1]) && (part[CHUNK-1] != a_in[REM_IN-1]);
                    zr_q  <= (sum_d == '0);
                    ng_q  <= part[CHUNK-1];
                end
            end

            assign bus.out_valid = valid_q;
            assign bus.sum       = sum_q;
            assign bus.cout      = carry_q;
            assign bus.ovf       = ovf_q;
            assign bus.zr        = zr_q;
            assign bus.ng        = ng_q;
        end
    end
endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: a 16/4 instance and an 8/8 instance checked against an
// arithmetic reference model and a table of hand-computed vectors.
module tb_pipe_add;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pipe_add_if #(.WIDTH(16)) if_a ();
    pipe_add_if #(.WIDTH(8))  if_b ();

    pipe_add #(.WIDTH(16), .CHUNK(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    pipe_add #(.WIDTH(8),  .CHUNK(8)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    typedef struct {
        longint sum;
        bit     cout;
        bit     ovf;
        bit     zr;
        bit     ng;
    } res_t;

    typedef struct {
        int     d;
        longint a;
        longint b;
        bit     cin;
        bit     sub;
        longint sum;
        bit     cout;
        bit     ovf;
        bit     zr;
        bit     ng;
    } vec_t;

    int     errors  = 0;
    int     checks  = 0;
    int     acc_cnt = 0;
    res_t   sb0[$];
    res_t   sb1[$];
    bit     hold_v[2];
    longint hold_t[2];
    vec_t   vecs[9];

    function automatic longint pk(longint s, bit c, bit o, bit z, bit n);
        return {s[59:0], c, o, z, n};
    endfunction

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic res_t model(int w, longint a_raw, longint b_raw, bit cin, bit sub);
        res_t   r;
        longint one = 1;
        longint m, half, a, b, sa, sb, sr, full;
        m    = (one << w) - 1;
        half = one << (w - 1);
        a    = a_raw & m;
        b    = b_raw & m;
        sa   = (a >= half) ? a - (one << w) : a;
        sb   = (b >= half) ? b - (one << w) : b;
        if (sub) begin
            full   = a + (one << w) - b;
            r.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            full   = a + b + longint'(cin);
            r.cout = full[w];
            sr     = sa + sb + longint'(cin);
        end
        r.sum = full & m;
        r.ovf = (sr >= half) || (sr < -half);
        r.zr  = (r.sum == 0);
        r.ng  = r.sum[w-1];
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit iv, input longint a, input longint b,
                         input bit cin, input bit sub, input bit ordy);
        if (d == 0) begin
            if_a.in_valid = iv; if_a.a = a[15:0]; if_a.b = b[15:0];
            if_a.cin = cin; if_a.sub = sub; if_a.out_ready = ordy;
        end else begin
            if_b.in_valid = iv; if_b.a = a[7:0]; if_b.b = b[7:0];
            if_b.cin = cin; if_b.sub = sub; if_b.out_ready = ordy;
        end
    endtask

    task automatic rd(input int d, output bit ov, output bit rdy, output longint tup);
        if (d == 0) begin
            ov = if_a.out_valid; rdy = if_a.in_ready;
            tup = pk(longint'(if_a.sum), if_a.cout, if_a.ovf, if_a.zr, if_a.ng);
        end else begin
            ov = if_b.out_valid; rdy = if_b.in_ready;
            tup = pk(longint'(if_b.sum), if_b.cout, if_b.ovf, if_b.zr, if_b.ng);
        end
    endtask

    // One clock cycle on DUT d: drive, check handshake/hold/scoreboard, advance.
    task automatic cyc(input int d, input bit iv, input longint a, input longint b,
                       input bit cin, input bit sub, input bit ordy);
        bit     ov, rdy, empty;
        longint tup;
        res_t   e;
        drive(d, iv, a, b, cin, sub, ordy);
        #1;
        rd(d, ov, rdy, tup);
        chk(rdy == (!ov || ordy), "in_ready", longint'(rdy), longint'(!ov || ordy));
        if (hold_v[d])
            chk(ov && (tup == hold_t[d]), "hold_stable", tup, hold_t[d]);
        if (ov && ordy) begin
            empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                chk(1'b0, "unexpected_out", tup, 0);
            end else begin
                e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                chk(tup == pk(e.sum, e.cout, e.ovf, e.zr, e.ng), "result", tup,
                    pk(e.sum, e.cout, e.ovf, e.zr, e.ng));
                $display("dut%0d out sum=%0h flags(c,v,z,n)=%0h", d, tup >> 4, tup & 15);
            end
        end
        if (iv && rdy) begin
            if (d == 0) sb0.push_back(model(16, a, b, cin, sub));
            else        sb1.push_back(model(8, a, b, cin, sub));
            acc_cnt++;
        end
        hold_v[d] = ov && !ordy;
        hold_t[d] = tup;
        tick();
    endtask

    task automatic drain(input int d);
        int left;
        left = (d == 0) ? sb0.size() : sb1.size();
        for (int k = 0; k < 40 && left > 0; k++) begin
            cyc(d, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
            left = (d == 0) ? sb0.size() : sb1.size();
        end
        chk(left == 0, "drain", left, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit     ov, rdy;
        longint tup;
        int     stages;
        stages = (v.d == 0) ? 4 : 1;
        $display("dut%0d vec a=%0h b=%0h cin=%0d sub=%0d", v.d, v.a, v.b, v.cin, v.sub);
        cyc(v.d, 1'b1, v.a, v.b, v.cin, v.sub, 1'b1);
        for (int k = 1; k < stages; k++) begin
            rd(v.d, ov, rdy, tup);
            chk(!ov, "latency_early", longint'(ov), 0);
            cyc(v.d, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        end
        rd(v.d, ov, rdy, tup);
        chk(ov, "latency_valid", longint'(ov), 1);
        chk(tup == pk(v.sum, v.cout, v.ovf, v.zr, v.ng), "vector", tup,
            pk(v.sum, v.cout, v.ovf, v.zr, v.ng));
        cyc(v.d, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit     ov, rdy;
        longint tup;
        int     start;
        bit     ordy;

        vecs[0] = '{0, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{0, 64'h00FF, 64'h0000, 1'b1, 1'b0, 64'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 64'h0005, 64'h0007, 1'b1, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{0, 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{0, 64'h0003, 64'h0003, 1'b0, 1'b1, 64'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1, 64'h80,   64'h80,   1'b0, 1'b0, 64'h00,   1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1, 64'h00,   64'h01,   1'b0, 1'b1, 64'hFF,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1, 64'h7F,   64'h00,   1'b1, 1'b0, 64'h80,   1'b0, 1'b1, 1'b0, 1'b1};
        hold_v = '{1'b0, 1'b0};
        hold_t = '{0, 0};

        // Reset with in_valid held high: nothing may be accepted.
        reset_n = 1'b0;
        drive(0, 1'b1, 64'h1111, 64'h2222, 1'b1, 1'b0, 1'b1);
        drive(1, 1'b1, 64'h33, 64'h44, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            rd(d, ov, rdy, tup);
            chk(!ov, "reset_out_valid", longint'(ov), 0);
            chk(tup == 0, "reset_outputs", tup, 0);
        end
        drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            rd(d, ov, rdy, tup);
            chk(rdy, "in_ready_after_reset", longint'(rdy), 1);
        end
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 2; d++) begin
                rd(d, ov, rdy, tup);
                chk(!ov, "no_accept_in_reset", longint'(ov), 0);
            end
            tick();
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Six back-to-back beats with out_ready dropped for cycles 4..6.
        start = acc_cnt;
        for (int c = 0; c < 40 && ((acc_cnt - start) < 6 || sb0.size() > 0); c++) begin
            ordy = !(c >= 4 && c < 7);
            if (c >= 4) begin
                rd(0, ov, rdy, tup);
                if (sb0.size() > 0) chk(ov, "no_gap", longint'(ov), 1);
            end
            cyc(0, (acc_cnt - start) < 6, longint'($urandom), longint'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
        end
        chk(acc_cnt - start == 6, "stall_beats", acc_cnt - start, 6);
        chk(sb0.size() == 0, "stall_all_out", sb0.size(), 0);

        // Reset with three beats in flight: none of them may ever emerge.
        for (int k = 0; k < 3; k++)
            cyc(0, 1'b1, 64'h0100 * k, 64'h0011, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        drive(0, 1'b1, 64'hABCD, 64'h1234, 1'b0, 1'b0, 1'b1);
        tick();
        reset_n = 1'b1;
        drive(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        sb0.delete();
        hold_v = '{1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            rd(0, ov, rdy, tup);
            chk(!ov, "post_reset_quiet", longint'(ov), 0);
            cyc(0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        end
        cyc(0, 1'b1, 64'h1234, 64'h0101, 1'b0, 1'b0, 1'b1);
        drain(0);

        // Random traffic with random bubbles and back-pressure on both instances.
        for (int d = 0; d < 2; d++) begin
            start = acc_cnt;
            for (int k = 0; k < 60000 && (acc_cnt - start) < 10000; k++)
                cyc(d, $urandom_range(0, 3) != 0, longint'($urandom), longint'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            chk(acc_cnt - start == 10000, "rand_accepted", acc_cnt - start, 10000);
            drain(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
